// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result transmit path.
package calc_pkg;

  localparam int unsigned RESULT_W   = 9;
  localparam int unsigned BCD_DIGITS = 3;

  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SIGN,
    HUND,
    TENS,
    ONES,
    CR,
    LF
  } tx_state_t;

  // Double-dabble correction: a BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RESULT_W-1:0] bin,
  output logic                done,
  output logic [3:0]          hund,
  output logic [3:0]          tens,
  output logic [3:0]          ones
);

  logic [RESULT_W-1:0]     sh;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [4*BCD_DIGITS-1:0] bcd_adj;
  logic [3:0]              cnt;

  // Per-digit add-3 correction applied ahead of each shift.
  always_comb begin
    bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  end

  // The load cycle also performs the first shift: with an all-zero BCD field
  // no correction is needed, so the nine shifts finish eight cycles after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd <= {{(4*BCD_DIGITS-1){1'b0}}, bin[RESULT_W-1]};
        sh  <= {bin[RESULT_W-2:0], 1'b0};
        cnt <= 4'(RESULT_W - 1);
      end else if (cnt != 4'd0) begin
        {bcd, sh} <= {bcd_adj, sh} << 1;
        cnt       <= cnt - 4'd1;
        done      <= (cnt == 4'd1);
      end
    end
  end

  assign hund = bcd[11:8];
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

endmodule

// File: rtl/result_tx_formatter.sv
// Streams each ALU result as an ASCII decimal line over the txdata/txclk/txready port.
module result_tx_formatter
  import calc_pkg::*;
#(
  parameter bit LZ_SUPPRESS = 1'b1,
  parameter bit EOL_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] result,
  input  logic       sign,
  input  logic       result_valid,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       overrun
);

  tx_state_t  state, next_state, first_digit;
  logic       sign_r;
  logic [8:0] mag_r;
  logic       conv_start, conv_done;
  logic [3:0] hund, tens, ones;
  logic [7:0] byte_next;

  assign conv_start = (state == IDLE) && result_valid;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (result),
    .done  (conv_done),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones)
  );

  // State register, captured operands, byte register and overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      mag_r   <= '0;
      txdata  <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= next_state;
      txdata  <= byte_next;
      overrun <= result_valid && busy;
      if (conv_start) begin
        sign_r <= sign;
        mag_r  <= result;
      end
    end
  end

  // First digit state to send, honouring leading-zero suppression.
  always_comb begin
    if (hund != 4'd0 || !LZ_SUPPRESS)
      first_digit = HUND;
    else if (tens != 4'd0)
      first_digit = TENS;
    else
      first_digit = ONES;
  end

  // Next-state logic: send states advance only on a transfer.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (result_valid) next_state = CONV;
      CONV: if (conv_done) next_state = (sign_r && mag_r != '0) ? SIGN : first_digit;
      SIGN: if (txclk) next_state = first_digit;
      HUND: if (txclk) next_state = TENS;
      TENS: if (txclk) next_state = ONES;
      ONES: if (txclk) next_state = EOL_EN ? CR : IDLE;
      CR:   if (txclk) next_state = LF;
      LF:   if (txclk) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte loaded for the state being entered; outside send states the last byte holds.
  always_comb begin
    byte_next = txdata;
    unique case (next_state)
      SIGN:    byte_next = ASC_MINUS;
      HUND:    byte_next = ASC_ZERO + {4'b0, hund};
      TENS:    byte_next = ASC_ZERO + {4'b0, tens};
      ONES:    byte_next = ASC_ZERO + {4'b0, ones};
      CR:      byte_next = ASC_CR;
      LF:      byte_next = ASC_LF;
      default: byte_next = txdata;
    endcase
  end

  // Handshake and status outputs from registered state.
  always_comb begin
    txclk = 1'b0;
    busy  = (state != IDLE);
    unique case (state)
      SIGN, HUND, TENS, ONES, CR, LF: txclk = txready;
      default:                        txclk = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_result_tx_formatter.sv
// Directed bench: default, LZ_SUPPRESS=0 and EOL_EN=0 instances share inputs.
module tb_result_tx_formatter;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] result;
  logic       sign;
  logic       result_valid;
  logic       txready;
  logic [7:0] txd [3];
  logic       txc [3];
  logic       bsy [3];
  logic       ovr [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  result_tx_formatter u_dut0 (
    .clk(clk), .reset(reset), .result(result), .sign(sign), .result_valid(result_valid),
    .txready(txready), .txdata(txd[0]), .txclk(txc[0]), .busy(bsy[0]), .overrun(ovr[0]));

  result_tx_formatter #(.LZ_SUPPRESS(1'b0), .EOL_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .result(result), .sign(sign), .result_valid(result_valid),
    .txready(txready), .txdata(txd[1]), .txclk(txc[1]), .busy(bsy[1]), .overrun(ovr[1]));

  result_tx_formatter #(.LZ_SUPPRESS(1'b1), .EOL_EN(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .result(result), .sign(sign), .result_valid(result_valid),
    .txready(txready), .txdata(txd[2]), .txclk(txc[2]), .busy(bsy[2]), .overrun(ovr[2]));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Strobe one value, collect n bytes from instance d and check them in order.
  // inj_at>0 issues an extra strobe in the cycle carrying byte number inj_at.
  task automatic run_line(input string tag, input int d, input logic sgn, input logic [8:0] val,
                          input logic [47:0] exp, input int n, input bit toggle, input int inj_at);
    int         got = 0;
    int         first_k = -1;
    int         ostage = 0;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_d = '0;
    sign = sgn; result = val; result_valid = 1'b1;
    @(posedge clk); #1 result_valid = 1'b0;
    for (int k = 1; k <= 120 && got < n; k++) begin
      @(posedge clk); #1;
      if (ostage == 1) begin
        result_valid = 1'b0;
        check({tag, "_ovr_pulse"}, 16'(ovr[d]), 16'd1);
        ostage = 2;
      end else if (ostage == 2) begin
        check({tag, "_ovr_once"}, 16'(ovr[d]), 16'd0);
        ostage = 0;
      end
      txready = toggle ? (k % 3 == 0) : 1'b1;
      #1;
      if (prev_hold) check({tag, "_stall_hold"}, 16'(txd[d]), 16'(prev_d));
      if (!txready) check({tag, "_stall_txclk"}, 16'(txc[d]), 16'd0);
      prev_hold = bsy[d] && !txc[d] && got > 0;
      prev_d    = txd[d];
      if (txc[d]) begin
        if (first_k < 0) begin
          first_k = k;
          check({tag, "_latency"}, 16'(first_k), 16'd9);
        end
        check({tag, "_byte"}, 16'(txd[d]), 16'(exp[47 - 8*got -: 8]));
        got++;
        if (got == inj_at) begin
          sign = 1'b0; result = 9'd456; result_valid = 1'b1;
          ostage = 1;
        end
      end
    end
    check({tag, "_count"}, 16'(got), 16'(n));
    @(posedge clk); #1;
    if (ostage == 1) begin
      result_valid = 1'b0;
      check({tag, "_ovr_last"}, 16'(ovr[d]), 16'd1);
    end
    txready = 1'b1;
    #1;
    check({tag, "_busy_end"}, 16'(bsy[d]), 16'd0);
    check({tag, "_txclk_end"}, 16'(txc[d]), 16'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; result = '0; sign = 1'b0; result_valid = 1'b0; txready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_txdata", 16'(txd[0]), 16'h00);
    check("rst_txclk", 16'(txc[0]), 16'd0);
    check("rst_busy", 16'(bsy[0]), 16'd0);
    check("rst_overrun", 16'(ovr[0]), 16'd0);
    reset = 1'b0;
    idle(2);

    run_line("p123", 0, 1'b0, 9'd123, 48'h3132330D0A00, 5, 1'b0, 0);
    run_line("n45",  0, 1'b1, 9'd45,  48'h2D34350D0A00, 5, 1'b0, 0);
    run_line("n0",   0, 1'b1, 9'd0,   48'h300D0A000000, 3, 1'b0, 0);
    run_line("p5",   0, 1'b0, 9'd5,   48'h350D0A000000, 3, 1'b0, 0);
    run_line("p80",  0, 1'b0, 9'd80,  48'h38300D0A0000, 4, 1'b0, 0);
    run_line("p105", 0, 1'b0, 9'd105, 48'h3130350D0A00, 5, 1'b0, 0);
    run_line("n511", 0, 1'b1, 9'd511, 48'h2D3531310D0A, 6, 1'b0, 0);
    idle(20);
    run_line("lz7",  1, 1'b0, 9'd7,   48'h3030370D0A00, 5, 1'b0, 0);
    idle(20);
    run_line("ne511", 2, 1'b0, 9'd511, 48'h353131000000, 3, 1'b0, 0);
    run_line("ne0",   2, 1'b0, 9'd0,   48'h300000000000, 1, 1'b0, 0);
    idle(20);
    run_line("stall200", 0, 1'b0, 9'd200, 48'h3230300D0A00, 5, 1'b1, 0);
    idle(20);
    run_line("ovr_mid",  0, 1'b0, 9'd123, 48'h3132330D0A00, 5, 1'b0, 2);
    run_line("ovr_last", 0, 1'b0, 9'd123, 48'h3132330D0A00, 5, 1'b0, 5);
    run_line("after",    0, 1'b0, 9'd45,  48'h34350D0A0000, 4, 1'b0, 0);
    idle(20);

    // Abort a line right after its first byte.
    sign = 1'b0; result = 9'd123; result_valid = 1'b1;
    @(posedge clk); #1 result_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk); #2;
      if (txc[0]) found = 1'b1;
    end
    check("abort_found", 16'(found), 16'd1);
    check("abort_first", 16'(txd[0]), 16'h31);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("abort_txclk", 16'(txc[0]), 16'd0);
    check("abort_busy", 16'(bsy[0]), 16'd0);
    check("abort_txdata", 16'(txd[0]), 16'h00);
    @(posedge clk); #1 reset = 1'b0;
    idle(1);
    run_line("fresh", 0, 1'b0, 9'd123, 48'h3132330D0A00, 5, 1'b0, 0);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
